seq_pattern_ctrl: RTL
=====================

Name: seq_pattern_ctrl

Overview:
Programmable serial pattern-detection controller. It holds a run-time pattern configuration (pattern bits, length, overlap mode, match target) and sequences detection over a qualified serial bitstream. It counts matches and stops the run when the target is reached. It sits between the control/config interface and the serial input, replacing fixed-pattern detectors with one configurable, armed/disarmed unit.

Parameters:
MAXLEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of cfg_len; must hold MAXLEN
CNT_W, 8, width of match counter and target

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  write config registers (accepted only in IDLE or DONE)
cfg_pattern  input  MAXLEN  pattern; bit cfg_len-1 is the first bit received
cfg_len  input  LEN_W  pattern length; legal range 1..MAXLEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match
cfg_target  input  CNT_W  matches needed to finish; 0 = unlimited
start  input  1  arm the detector
abort  input  1  stop the run and return to IDLE
x  input  1  serial data bit
x_valid  input  1  x is sampled only when high
z  output  1  one-cycle match pulse
busy  output  1  high in RUN
done  output  1  high in DONE
match_cnt  output  CNT_W  matches in the current or last run
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Single clock domain. All outputs are registered.
- Asynchronous reset (rst_n low) forces:
  - state = IDLE; z = 0, busy = 0, done = 0, match_cnt = 0, cfg_err = 0
  - history = 0, bits_seen = 0
  - config registers: pattern = 0, len = 1, overlap = 0, target = 0
- States: IDLE, RUN, DONE.
- Config registers load on cfg_we in IDLE or DONE. cfg_we is ignored in RUN.
- IDLE:
  - start with stored len in 1..MAXLEN -> RUN. At the same edge, match_cnt, history and bits_seen are cleared.
  - start with len = 0 or len > MAXLEN -> cfg_err = 1 for one cycle; stay IDLE.
  - If cfg_we and start occur in the same cycle, start uses the previously stored config.
- RUN, on each edge with x_valid = 1:
  - history <= {history[MAXLEN-2:0], x}
  - bits_seen increments, saturating at len
  - The match test uses the updated history: bits_seen (after increment) >= len AND history[len-1:0] == pattern[len-1:0].
  - On match:
    - z = 1 in the following cycle (one-cycle latency from the sampling edge)
    - match_cnt increments, saturating at all-ones
    - overlap = 0 -> history and bits_seen clear, so the matching bit is not reused
    - overlap = 1 -> history is kept
  - If target != 0 and the incremented match_cnt == target -> DONE at the same edge (done = 1, busy = 0 next cycle).
- RUN, x_valid = 0: no shift and no match. Gaps of any length are transparent.
- abort in RUN -> IDLE. abort has priority over a same-cycle match: the bit is discarded, z stays 0, match_cnt keeps its prior value.
- abort and start in the same cycle in IDLE: abort wins; stay IDLE.
- DONE:
  - done held high; match_cnt held.
  - start -> RUN with match_cnt cleared (same legality check as IDLE).
  - abort -> IDLE.
- z is never asserted outside the cycle after a matching RUN edge.
- match_cnt persists in IDLE after an abort until the next accepted start.
- len = 1 is legal: every valid bit equal to pattern[0] matches.

Test Plan:
1. Pattern 1011 (cfg_pattern = 8'b0000_1011), len = 4, overlap = 1, target = 0; stream 1,0,1,1,0,1,1 with x_valid = 1 -> z pulses the cycle after bit 4 and after bit 7; match_cnt = 2; busy stays 1.
2. Same stream with overlap = 0 -> single z pulse after bit 4; match_cnt = 1.
3. Pattern 1010, len = 4, overlap = 1, target = 2; stream 1,0,1,0,1,0 with x_valid low every other cycle -> matches after bits 4 and 6. DONE entered at the second match: done = 1, busy = 0, match_cnt = 2. Further bits produce no z.
4. cfg_len = 0, then start -> cfg_err pulses once, state stays IDLE, busy = 0. Then cfg_len = 4, start -> busy = 1.
5. RUN with pattern 11, len = 2; assert abort on the edge where the second 1 is sampled -> no z, match_cnt = 0, busy = 0 next cycle. cfg_we during RUN (before the abort) leaves the stored pattern unchanged.
6. rst_n low asynchronously mid-RUN, between clock edges -> z, busy, done, match_cnt = 0 immediately. After release, start with the default config (len = 1, pattern bit 0 = 0) -> each valid x = 0 produces a z pulse.

Source files
------------

// File: rtl/seq_pattern_ctrl.sv
// Programmable serial pattern detector with match counting.
// Armed by start, stops on abort or when the match target is reached.
module seq_pattern_ctrl #(
    parameter int MAXLEN = 8,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_target,
    input  logic              start,
    input  logic              abort,
    input  logic              x,
    input  logic              x_valid,
    output logic              z,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [MAXLEN-1:0] pat;
    logic [LEN_W-1:0]  len;
    logic              ovl;
    logic [CNT_W-1:0]  tgt;
    logic [MAXLEN-1:0] hist, hist_n;
    logic [LEN_W-1:0]  seen, seen_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              z_n, err_n;

    logic [MAXLEN-1:0] shift, mask;
    logic [LEN_W-1:0]  seen_inc;
    logic [CNT_W-1:0]  cnt_inc;
    logic              len_ok, hit;

    // Config registers are frozen while a run is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat <= '0;
            len <= LEN_W'(1);
            ovl <= 1'b0;
            tgt <= '0;
        end else if (cfg_we && state != RUN) begin
            pat <= cfg_pattern;
            len <= cfg_len;
            ovl <= cfg_overlap;
            tgt <= cfg_target;
        end
    end

    // Match evaluation on the history as it will be after this bit
    always_comb begin
        shift    = {hist[MAXLEN-2:0], x};
        seen_inc = (seen < len) ? seen + 1'b1 : seen;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(len));
        end
        hit     = (seen_inc >= len) && ((shift & mask) == (pat & mask));
        cnt_inc = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
        len_ok  = (len != '0) && (len <= LEN_W'(MAXLEN));
    end

    // Next-state and next-output logic; abort dominates everything
    always_comb begin
        state_n = state;
        hist_n  = hist;
        seen_n  = seen;
        cnt_n   = match_cnt;
        z_n     = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (start) begin
                    if (len_ok) begin
                        state_n = RUN;
                        cnt_n   = '0;
                        hist_n  = '0;
                        seen_n  = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (x_valid) begin
                    hist_n = shift;
                    seen_n = seen_inc;
                    if (hit) begin
                        z_n   = 1'b1;
                        cnt_n = cnt_inc;
                        if (!ovl) begin
                            hist_n = '0;
                            seen_n = '0;
                        end
                        if (tgt != '0 && cnt_inc == tgt) begin
                            state_n = DONE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, history and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hist      <= '0;
            seen      <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            seen      <= seen_n;
            match_cnt <= cnt_n;
            z         <= z_n;
            busy      <= (state_n == RUN);
            done      <= (state_n == DONE);
            cfg_err   <= err_n;
        end
    end

endmodule
